// File: rtl/pwm_capture_if.sv
// Signal bundle for pwm_capture: PWM input plus recovered duty/period and status.
interface pwm_capture_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
);
  logic             pwm_in;
  logic [N-1:0]     duty;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             busy;
  logic             overrun;
  logic             stuck;

  modport master (
    output pwm_in,
    input  duty, period, valid, busy, overrun, stuck
  );

  modport slave (
    input  pwm_in,
    output duty, period, valid, busy, overrun, stuck
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures period/high time between rising edges and normalises high/period to N bits.
// Optional 2-sample deglitch filter after the synchroniser: define PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam int unsigned      DivCntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StMeas, StDiv} state_e;

  state_e state_q, state_d;

  logic               sync1_q, sync2_q, s_d1_q, s, rise;
  logic [CNT_W-1:0]   cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d;
  logic               stuck_evt;
  logic               busy, capture, drop, div_step, div_last, div_done;
  logic [CNT_W-1:0]   period_cap_q, rem_q, rem_d;
  logic [N-1:0]       quo_q, quo_d;
  logic [DivCntW-1:0] div_cnt_q;
  logic               q_bit;
  logic [N-1:0]       duty_q;
  logic [CNT_W-1:0]   period_q;
  logic               valid_q, overrun_q, stuck_q;

  // Input synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_d1_q  <= 1'b0;
    end else begin
      sync1_q <= bus.pwm_in;
      sync2_q <= sync1_q;
      s_d1_q  <= s;
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  logic sync3_q, filt_q;

  // Level only follows after two equal consecutive synced samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync3_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      sync3_q <= sync2_q;
      if (sync2_q == sync3_q) filt_q <= sync2_q;
    end
  end

  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  assign rise      = s & ~s_d1_q;
  assign stuck_evt = ~rise & (cnt_p_q == (CntMax - CNT_W'(1)));

  // Period/high counters, both saturating
  always_comb begin
    cnt_p_d = cnt_p_q;
    cnt_h_d = cnt_h_q;
    if (rise) begin
      cnt_p_d = CNT_W'(1);
      cnt_h_d = CNT_W'(1);
    end else begin
      if (cnt_p_q != CntMax)        cnt_p_d = cnt_p_q + CNT_W'(1);
      if (s && (cnt_h_q != CntMax)) cnt_h_d = cnt_h_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p_q <= '0;
      cnt_h_q <= '0;
    end else begin
      cnt_p_q <= cnt_p_d;
      cnt_h_q <= cnt_h_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rise) state_d = StMeas;
      StMeas:  if (rise) state_d = StDiv;
      StDiv:   if (div_last) state_d = StMeas;
      default: state_d = StIdle;
    endcase
    if (stuck_evt) state_d = StIdle;
  end

  // FSM: outputs
  always_comb begin
    busy     = (state_q == StDiv);
    capture  = rise & (state_q == StMeas);
    drop     = rise & (state_q == StDiv);
    div_step = (state_q == StDiv);
    div_done = div_step & div_last & ~stuck_evt;
  end

  assign div_last = (div_cnt_q == DivCntW'(N - 1));

  // Restoring divide of {high, N'b0} by period; high < period so the remainder starts at high.
  assign q_bit = ({rem_q, 1'b0} >= {1'b0, period_cap_q});
  assign rem_d = CNT_W'(q_bit ? ({rem_q, 1'b0} - {1'b0, period_cap_q}) : {rem_q, 1'b0});
  assign quo_d = N'({quo_q, q_bit});

  always_ff @(posedge clk) begin
    if (reset) begin
      period_cap_q <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      div_cnt_q    <= '0;
    end else if (capture) begin
      period_cap_q <= cnt_p_q;
      rem_q        <= cnt_h_q;
      quo_q        <= '0;
      div_cnt_q    <= '0;
    end else if (div_step) begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_cnt_q <= div_cnt_q + DivCntW'(1);
    end
  end

  // Result/status registers; a stuck event overrides a completing divide.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= drop;
      if (stuck_evt) begin
        stuck_q  <= 1'b1;
        valid_q  <= 1'b1;
        period_q <= CntMax;
        duty_q   <= s ? '1 : '0;
      end else if (div_done) begin
        valid_q  <= 1'b1;
        period_q <= period_cap_q;
        duty_q   <= quo_d;
      end
      if (rise) stuck_q <= 1'b0;
    end
  end

  assign bus.duty    = duty_q;
  assign bus.period  = period_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy;
  assign bus.overrun = overrun_q;
  assign bus.stuck   = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: directed PWM streams, expected results queued at stimulus time.
module tb_pwm_capture;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 12;
  localparam logic [CNT_W-1:0] PerMax = '1;

  typedef struct packed {
    logic [N-1:0]     duty;
    logic [CNT_W-1:0] period;
    logic             stuck;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   ovr_cnt = 0;

  always #5 clk = ~clk;

  pwm_capture_if #(.N(N), .CNT_W(CNT_W)) bus ();

  pwm_capture #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push_raw(input int duty, input int period, input logic st);
    exp_t e;
    e.duty   = N'(duty);
    e.period = CNT_W'(period);
    e.stuck  = st;
    exp_q.push_back(e);
  endtask

  // Expected duty = floor(high * 2^N / period)
  task automatic push(input int h, input int p);
    push_raw((h << N) / p, p, 1'b0);
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      bus.pwm_in = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int l, input bit chk);
    if (chk) push(h, h + l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pop and compare on every valid strobe
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.overrun) ovr_cnt++;
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_valid: got duty %0d period %0d, required no valid",
                   bus.duty, bus.period);
        end else begin
          e = exp_q.pop_front();
          check("duty",   32'(bus.duty),   32'(e.duty));
          check("period", 32'(bus.period), 32'(e.period));
          check("stuck_on_valid", 32'(bus.stuck), 32'(e.stuck));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int k;
    reset      = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_duty",    32'(bus.duty),    32'd0);
    check("reset_period",  32'(bus.period),  32'd0);
    check("reset_valid",   32'(bus.valid),   32'd0);
    check("reset_busy",    32'(bus.busy),    32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);
    check("reset_stuck",   32'(bus.stuck),   32'd0);

    @(posedge clk);
    #1;
    drive(1'b0, 10);
    // Period 256, high 64
    repeat (4) pulse(64, 192, 1'b1);
    // Extreme duties
`ifdef PWM_CAPTURE_DEGLITCH_EN
    pulse(254, 2, 1'b1);
    pulse(2, 254, 1'b1);
`else
    pulse(255, 1, 1'b1);
    pulse(1, 255, 1'b1);
`endif
    // Period 300, high 150 -> 128
    repeat (2) pulse(150, 150, 1'b1);
    // 1-cycle low glitch inside the high phase
`ifdef PWM_CAPTURE_DEGLITCH_EN
    push(64, 256);
`else
    push(30, 31);
    push(33, 225);
`endif
    drive(1'b1, 30);
    drive(1'b0, 1);
    drive(1'b1, 33);
    drive(1'b0, 192);
    check("overrun_none_slow", 32'(ovr_cnt), 32'd0);

    // Period 5: every other interval dropped while the divider is busy
    repeat (3) begin
      pulse(2, 3, 1'b0);
      pulse(2, 3, 1'b1);
    end
    pulse(64, 192, 1'b0);
    wait_drain("drain_fast");
    check("overrun_count", 32'(ovr_cnt), 32'd3);

    // Reset in the middle of a divide
    bus.pwm_in = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.busy && k < 12);
    check("busy_seen", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    bus.pwm_in = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_duty",    32'(bus.duty),    32'd0);
    check("abort_period",  32'(bus.period),  32'd0);
    check("abort_valid",   32'(bus.valid),   32'd0);
    check("abort_busy",    32'(bus.busy),    32'd0);
    check("abort_overrun", 32'(bus.overrun), 32'd0);
    check("abort_stuck",   32'(bus.stuck),   32'd0);
    reset = 1'b0;

    // Stuck low from reset
    repeat (4000) @(posedge clk);
    #1;
    check("stuck_early", 32'(bus.stuck), 32'd0);
    push_raw(0, int'(PerMax), 1'b1);
    k = 0;
    while (!bus.stuck && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("stuck_low", 32'(bus.stuck), 32'd1);

    // Rise clears stuck; then stuck high
    @(posedge clk);
    #1;
    bus.pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    check("stuck_clear", 32'(bus.stuck), 32'd0);
    push_raw((1 << N) - 1, int'(PerMax), 1'b1);
    k = 0;
    while (!bus.stuck && k < 4200) begin
      @(negedge clk);
      k++;
    end
    check("stuck_high", 32'(bus.stuck), 32'd1);
    @(negedge clk);
    check("stuck_duty_held", 32'(bus.duty), 32'((1 << N) - 1));

    @(posedge clk);
    #1;
    drive(1'b0, 10);
    drive(1'b1, 10);
    check("stuck_clear2", 32'(bus.stuck), 32'd0);
    drive(1'b0, 20);
    wait_drain("drain_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
